cfg_join_dat: RTL and testbench

- Inverse of the config field splitter: NFIELDS independent field streams are gathered into one wide word on a single output stream.
- Each field input has its own valid/ready handshake and a one-deep holding slot.
- When every slot is full, the fields are concatenated and moved into a registered output stage.
- Sits in elastic datapath pipelines wherever separately produced config/data fields must be merged before a wide consumer.

---
 rtl/cfg_join_dat_pkg.sv | 15 +
 rtl/cfg_join_slot.sv | 36 +++
 rtl/cfg_join_dat.sv | 84 ++++++++
 tb/tb_cfg_join_dat.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_join_dat_pkg.sv
// Shared constants and width/offset helpers for the cfg_join_dat field joiner.
package cfg_join_dat_pkg;

  localparam int CNT_W = 16;

  function automatic int out_w(input int nfields, input int field_w);
    return nfields * field_w;
  endfunction

  // LSB of field k inside the joined word; field 0 lands in the MSBs.
  function automatic int join_lo(input int k, input int nfields, input int field_w);
    return (nfields - 1 - k) * field_w;
  endfunction

endpackage

// File: rtl/cfg_join_slot.sv
// One-deep holding slot for a single field stream of cfg_join_dat.
module cfg_join_slot #(
  parameter int FIELD_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FIELD_W-1:0] t_dat,
  input  logic               t_valid,
  output logic               t_ready,
  input  logic               join_fire,
  input  logic               flush,
  output logic [FIELD_W-1:0] dat,
  output logic               full
);

  logic accept;

  // A full slot frees up on the same edge the join consumes it.
  assign t_ready = !flush && (!full || join_fire);
  assign accept  = t_valid && t_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      dat  <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
      dat  <= t_dat;
    end else if (join_fire) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cfg_join_dat.sv
// Joins NFIELDS field streams into one registered wide word.
// Optional handshake counter output i_0_cnt when CFG_JOIN_DAT_CNT_EN is defined.
module cfg_join_dat
  import cfg_join_dat_pkg::*;
#(
  parameter int NFIELDS = 4,
  parameter int FIELD_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NFIELDS*FIELD_W-1:0] t_dat,
  input  logic [NFIELDS-1:0]         t_valid,
  output logic [NFIELDS-1:0]         t_ready,
  input  logic                       flush,
  output logic [NFIELDS*FIELD_W-1:0] i_0_dat,
  output logic                       i_0_valid,
`ifdef CFG_JOIN_DAT_CNT_EN
  output logic [CNT_W-1:0]           i_0_cnt,
`endif
  input  logic                       i_0_ready
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and data holds while valid && !ready.

  localparam int OUT_W = out_w(NFIELDS, FIELD_W);

  logic [NFIELDS-1:0] full;
  logic [FIELD_W-1:0] slot_dat [NFIELDS];
  logic [OUT_W-1:0]   joined;
  logic               join_fire;

  assign join_fire = (&full) && (!i_0_valid || i_0_ready) && !flush;

  for (genvar k = 0; k < NFIELDS; k++) begin : g_slot
    cfg_join_slot #(
      .FIELD_W (FIELD_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .t_dat     (t_dat[k*FIELD_W +: FIELD_W]),
      .t_valid   (t_valid[k]),
      .t_ready   (t_ready[k]),
      .join_fire (join_fire),
      .flush     (flush),
      .dat       (slot_dat[k]),
      .full      (full[k])
    );
  end

  always_comb begin
    joined = '0;
    for (int k = 0; k < NFIELDS; k++) begin
      joined[join_lo(k, NFIELDS, FIELD_W) +: FIELD_W] = slot_dat[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_0_valid <= 1'b0;
      i_0_dat   <= '0;
    end else if (flush) begin
      i_0_valid <= 1'b0;
    end else if (join_fire) begin
      i_0_valid <= 1'b1;
      i_0_dat   <= joined;
    end else if (i_0_ready) begin
      i_0_valid <= 1'b0;
    end
  end

`ifdef CFG_JOIN_DAT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_0_cnt <= '0;
    end else if (flush) begin
      i_0_cnt <= '0;
    end else if (i_0_valid && i_0_ready) begin
      i_0_cnt <= i_0_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_join_dat.sv
// Directed self-checking bench for cfg_join_dat (NFIELDS=4, FIELD_W=8).
module tb_cfg_join_dat;

  localparam int NF = 4;
  localparam int FW = 8;
  localparam int W  = NF * FW;

  logic          clk;
  logic          reset;
  logic [W-1:0]  t_dat;
  logic [NF-1:0] t_valid;
  logic [NF-1:0] t_ready;
  logic          flush;
  logic [W-1:0]  i_0_dat;
  logic          i_0_valid;
  logic          i_0_ready;
`ifdef CFG_JOIN_DAT_CNT_EN
  logic [15:0]   i_0_cnt;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_pass;
  int hs_cnt;

  cfg_join_dat #(
    .NFIELDS (NF),
    .FIELD_W (FW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .t_dat     (t_dat),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .flush     (flush),
    .i_0_dat   (i_0_dat),
    .i_0_valid (i_0_valid),
`ifdef CFG_JOIN_DAT_CNT_EN
    .i_0_cnt   (i_0_cnt),
`endif
    .i_0_ready (i_0_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // field k goes to t_dat bits [k*8 +: 8]
  task automatic drive_set(input logic [7:0] f0, input logic [7:0] f1,
                           input logic [7:0] f2, input logic [7:0] f3,
                           input logic [NF-1:0] mask);
    t_dat   = {f3, f2, f1, f0};
    t_valid = mask;
  endtask

  function automatic logic [W-1:0] word_of(input logic [7:0] f0, input logic [7:0] f1,
                                           input logic [7:0] f2, input logic [7:0] f3);
    return {f0, f1, f2, f3};
  endfunction

  // scoreboard: every output handshake must match the oldest accepted set
  always @(negedge clk) begin
    if (!reset && i_0_valid && i_0_ready) begin
      hs_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_word", i_0_dat, exp_q.pop_front());
    end
  end

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      tick();
      budget++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] f [NF];
    logic [W-1:0] last_word;
    logic acc;
    int guard;
    int hs_start;

    n_checks = 0;
    n_pass   = 0;
    hs_cnt   = 0;
    reset    = 1'b1;
    t_dat    = '0;
    t_valid  = '0;
    flush    = 1'b0;
    i_0_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_t_ready", 32'(t_ready), 32'hF);
    check("rst_valid", 32'(i_0_valid), 32'd0);
    check("rst_dat", i_0_dat, 32'd0);
`ifdef CFG_JOIN_DAT_CNT_EN
    check("rst_cnt", 32'(i_0_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // basic join
    i_0_ready = 1'b1;
    drive_set(8'h11, 8'h22, 8'h33, 8'h44, 4'hF);
    #1;
    check("basic_t_ready", 32'(t_ready), 32'hF);
    exp_q.push_back(word_of(8'h11, 8'h22, 8'h33, 8'h44));
    tick();
    t_valid = '0;
    #1;
    check("basic_latency", 32'(i_0_valid), 32'd0);
    tick();
    check("basic_valid", 32'(i_0_valid), 32'd1);
    check("basic_dat", i_0_dat, 32'h11223344);
    tick();
    check("basic_one_cycle", 32'(i_0_valid), 32'd0);

    // skewed arrival: field 2 five cycles late
    drive_set(8'h11, 8'h22, 8'h00, 8'h44, 4'b1011);
    tick();
    t_valid = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("skew_t_ready", 32'(t_ready), 32'h4);
      check("skew_no_valid", 32'(i_0_valid), 32'd0);
      tick();
    end
    drive_set(8'h00, 8'h00, 8'h33, 8'h00, 4'b0100);
    exp_q.push_back(word_of(8'h11, 8'h22, 8'h33, 8'h44));
    tick();
    t_valid = '0;
    #1;
    check("skew_latency", 32'(i_0_valid), 32'd0);
    tick();
    check("skew_valid", 32'(i_0_valid), 32'd1);
    check("skew_dat", i_0_dat, 32'h11223344);
    drain("skew_drain");

    // backpressure: 8 words, output stalled for the first 10 cycles
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          for (int k = 0; k < NF; k++) f[k] = 8'(w * 16 + k);
          drive_set(f[0], f[1], f[2], f[3], 4'hF);
          guard = 0;
          do begin
            @(negedge clk);
            acc = (t_ready == 4'hF);
            tick();
            guard++;
          end while (!acc && guard < 100);
          check("bp_accept_timeout", 32'(acc), 32'd1);
          if (acc) exp_q.push_back(word_of(f[0], f[1], f[2], f[3]));
        end
        t_valid = '0;
      end
      begin
        i_0_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          tick();
          if (i >= 2) begin
            check("bp_hold_valid", 32'(i_0_valid), 32'd1);
            check("bp_hold_dat", i_0_dat, 32'h00010203);
            check("bp_t_ready_low", 32'(t_ready), 32'h0);
          end
        end
        i_0_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // full throughput
    hs_start = hs_cnt;
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < NF; k++) f[k] = 8'(8'hA0 + w * 16 + k);
      drive_set(f[0], f[1], f[2], f[3], 4'hF);
      exp_q.push_back(word_of(f[0], f[1], f[2], f[3]));
      last_word = word_of(f[0], f[1], f[2], f[3]);
      #1;
      check("tp_t_ready", 32'(t_ready), 32'hF);
      if (w >= 2) check("tp_valid", 32'(i_0_valid), 32'd1);
      tick();
    end
    t_valid = '0;
    drain("tp_drain");
    check("tp_count", 32'(hs_cnt - hs_start), 32'd6);
    tick();

    // flush drops partial data
    drive_set(8'hE0, 8'hE1, 8'h00, 8'h00, 4'b0011);
    tick();
    drive_set(8'h00, 8'h00, 8'hE2, 8'h00, 4'b0100);
    flush = 1'b1;
    #1;
    check("flush_t_ready", 32'(t_ready), 32'h0);
    tick();
    flush = 1'b0;
    t_valid = '0;
    #1;
    check("flush_valid", 32'(i_0_valid), 32'd0);
    check("flush_t_ready_after", 32'(t_ready), 32'hF);
    check("flush_dat_hold", i_0_dat, last_word);
`ifdef CFG_JOIN_DAT_CNT_EN
    check("flush_cnt", 32'(i_0_cnt), 32'd0);
`endif
    drive_set(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'hF);
    exp_q.push_back(32'hB0B1B2B3);
    tick();
    t_valid = '0;
    tick();
    check("flush_next_dat", i_0_dat, 32'hB0B1B2B3);
    drain("flush_drain");

    // async reset during an output stall
    i_0_ready = 1'b0;
    drive_set(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'hF);
    tick();
    drive_set(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'hF);
    tick();
    t_valid = '0;
    check("stall_valid", 32'(i_0_valid), 32'd1);
    check("stall_t_ready", 32'(t_ready), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(i_0_valid), 32'd0);
    check("arst_t_ready", 32'(t_ready), 32'hF);
    check("arst_dat", i_0_dat, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    i_0_ready = 1'b1;
    repeat (3) tick();
    check("arst_no_word", 32'(i_0_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
